conv_mac_res_cvt: RTL and testbench

- Sink for the conv MAC cell's result stream (`mac_out_exp`/`mac_out_frac`/`mac_out_valid`).
- Converts each result into a 32-bit word:
  - IEEE FP32 in FP16 mode.
  - Saturated int32 in integer modes.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the partial-sum path.
- The MAC cell cannot be stalled, so FIFO overflow drops results and is reported through sticky status.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/lead_one_det40.sv | 15 +
 rtl/res_fifo.sv | 44 ++++
 rtl/conv_mac_res_cvt.sv | 148 ++++++++++++++
 tb/tb_conv_mac_res_cvt.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared encodings, FP32 constants and stage types for the MAC result converter
package conv_pkg;

  localparam logic [1:0] CAL_FMT_INT8  = 2'b00;
  localparam logic [1:0] CAL_FMT_INT16 = 2'b01;
  localparam logic [1:0] CAL_FMT_FP16  = 2'b10;

  localparam int          FP32_BIAS     = 127;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP32_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic               valid;
    logic               fp;
    logic               sign;
    logic               zero;
    logic [39:0]        mag;
    logic [5:0]         lead;
    logic signed [10:0] exp_e;
    logic [31:0]        int_val;
  } s1_t;

  function automatic logic [31:0] sat_int32(input logic signed [39:0] v);
    if (v[39:31] == '0 || v[39:31] == '1) return v[31:0];
    else if (v[39]) return 32'h8000_0000;
    else return 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/lead_one_det40.sv
// rtl/lead_one_det40.sv - combinational position of the most significant set bit of a 40-bit word
module lead_one_det40 (
  input  logic [39:0] vec,
  output logic [5:0]  pos
);

  // Later iterations overwrite earlier ones, so the highest set bit wins; all-zero gives 0.
  always_comb begin
    pos = '0;
    for (int i = 0; i < 40; i++) begin
      if (vec[i]) pos = 6'(i);
    end
  end

endmodule

// File: rtl/res_fifo.sv
// rtl/res_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd, do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head is forced to zero while empty so stale storage never shows on the output.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/conv_mac_res_cvt.sv
// rtl/conv_mac_res_cvt.sv - converts MAC results to FP32 or saturated int32 and buffers them for the psum path
module conv_mac_res_cvt
  import conv_pkg::*;
#(
  parameter int EXP_BIAS   = 50,
  parameter int FIFO_DEPTH = 4,
  parameter int SIM_DELAY  = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        aclken,
  input  logic [1:0]  calfmt,
  input  logic [7:0]  mac_out_exp,
  input  logic [39:0] mac_out_frac,
  input  logic        mac_out_valid,
  output logic [31:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        ovf_sticky,
  output logic [7:0]  drop_cnt,
  input  logic        ovf_clr
);

  localparam logic signed [10:0] EXP_ADJ = 11'(FP32_BIAS - EXP_BIAS);

  logic unused_sim_delay;
  assign unused_sim_delay = (SIM_DELAY != 0);

  // S0: capture
  logic        s0_valid;
  logic [39:0] s0_frac;
  logic [7:0]  s0_exp;
  logic [1:0]  s0_fmt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s0_valid <= 1'b0;
      s0_frac  <= '0;
      s0_exp   <= '0;
      s0_fmt   <= '0;
    end else if (aclken) begin
      s0_valid <= mac_out_valid;
      s0_frac  <= mac_out_frac;
      s0_exp   <= mac_out_exp;
      s0_fmt   <= calfmt;
    end
  end

  // S1: magnitude, leading one, biased exponent
  logic        s0_sign;
  logic [39:0] s0_mag;
  logic [5:0]  s0_lead;
  s1_t         s1_d, s1;

  assign s0_sign = s0_frac[39];
  assign s0_mag  = s0_sign ? (~s0_frac + 40'd1) : s0_frac;

  lead_one_det40 u_lod (
    .vec (s0_mag),
    .pos (s0_lead)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = s0_valid;
    s1_d.fp      = (s0_fmt == CAL_FMT_FP16);
    s1_d.sign    = s0_sign;
    s1_d.zero    = (s0_mag == '0);
    s1_d.mag     = s0_mag;
    s1_d.lead    = s0_lead;
    s1_d.exp_e   = $signed({5'd0, s0_lead}) + $signed({3'd0, s0_exp}) + EXP_ADJ;
    s1_d.int_val = sat_int32(s0_frac);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      s1 <= '0;
    else if (aclken) s1 <= s1_d;
  end

  // S2: normalize so the leading one sits just above bit 38, then round to nearest-even
  logic [38:0]        norm;
  logic [22:0]        mant;
  logic               rnd_up;
  logic [23:0]        mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        fp_word, s2_word_d;

  always_comb begin
    norm    = 39'(s1.mag << (6'd39 - s1.lead));
    mant    = norm[38:16];
    rnd_up  = norm[15] && ((|norm[14:0]) || mant[0]);
    mant_r  = {1'b0, mant} + 24'(rnd_up);
    exp_r   = s1.exp_e + $signed({10'd0, mant_r[23]});
    fp_word = {s1.sign, exp_r[7:0], mant_r[22:0]};
    if (s1.zero)                fp_word = FP32_POS_ZERO;
    else if (exp_r >= 11'sd255) fp_word = {s1.sign, FP32_EXP_MAX, 23'd0};
    else if (exp_r <= 11'sd0)   fp_word = {s1.sign, 31'd0};
    s2_word_d = s1.fp ? fp_word : s1.int_val;
  end

  logic        s2_valid;
  logic [31:0] s2_word;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s2_valid <= 1'b0;
      s2_word  <= '0;
    end else if (aclken) begin
      s2_valid <= s1.valid;
      s2_word  <= s2_word_d;
    end
  end

  // Output buffer; the MAC cannot be stalled, so a full FIFO without a pop drops the result
  logic fifo_push, fifo_empty, fifo_full, drop;

  assign fifo_push = s2_valid && aclken;
  assign drop      = fifo_push && fifo_full && !res_ready;
  assign res_valid = !fifo_empty;

  res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (fifo_push),
    .pop   (res_ready),
    .wdata (s2_word),
    .rdata (res_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_conv_mac_res_cvt.sv
// tb/tb_conv_mac_res_cvt.sv - self-checking bench for conv_mac_res_cvt
module tb_conv_mac_res_cvt;

  logic        aclk = 1'b0;
  logic        areset, aclken, mac_out_valid, res_ready, ovf_clr;
  logic [1:0]  calfmt;
  logic [7:0]  mac_out_exp;
  logic [39:0] mac_out_frac;
  logic [31:0] res_data, res_data_b;
  logic        res_valid, res_valid_b, ovf_sticky, ovf_sticky_b;
  logic [7:0]  drop_cnt, drop_cnt_b;
  logic        res_ready_b = 1'b1;

  always #5 aclk = ~aclk;

  conv_mac_res_cvt dut (
    .aclk(aclk), .areset(areset), .aclken(aclken), .calfmt(calfmt),
    .mac_out_exp(mac_out_exp), .mac_out_frac(mac_out_frac), .mac_out_valid(mac_out_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  conv_mac_res_cvt #(.EXP_BIAS(200)) dut_b (
    .aclk(aclk), .areset(areset), .aclken(aclken), .calfmt(calfmt),
    .mac_out_exp(mac_out_exp), .mac_out_frac(mac_out_frac), .mac_out_valid(mac_out_valid),
    .res_data(res_data_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .ovf_sticky(ovf_sticky_b), .drop_cnt(drop_cnt_b), .ovf_clr(ovf_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  // Reference: exact value frac * 2^(exp-bias), rounded to 24 significant bits by integer division.
  function automatic logic [31:0] ref_fp(input logic signed [39:0] f, input int e, input int bias);
    logic [63:0] m, q, r, half;
    logic        s;
    int          p, ex, sh;
    s = f[39];
    m = s ? 64'(-longint'(f)) : 64'(longint'(f));
    if (m == 0) return 32'h0;
    p  = $clog2(m + 1) - 1;
    ex = p + e - bias + 127;
    if (p <= 23) q = m << (23 - p);
    else begin
      sh   = p - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
    end
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0};
    if (ex <= 0) return {s, 31'd0};
    return {s, 8'(ex), q[22:0]};
  endfunction

  function automatic logic [31:0] ref_int(input logic signed [39:0] f);
    longint v;
    v = longint'(f);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  // Behavioural model: three-deep pipeline of expected words feeding a bounded queue.
  logic        pv [3];
  logic [31:0] pd [3];
  logic [31:0] mq [$];
  int          m_cnt;
  logic        m_sticky;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    mq.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
  endtask

  task automatic cycle();
    logic        v, rdy, en, clr, pop, wr, drp;
    logic [31:0] w, wd;
    v   = mac_out_valid;
    rdy = res_ready;
    en  = aclken;
    clr = ovf_clr;
    w   = (calfmt == 2'b10) ? ref_fp(mac_out_frac, int'(mac_out_exp), 50) : ref_int(mac_out_frac);
    @(posedge aclk);
    #1;
    pop = (mq.size() > 0) && rdy;
    wr  = en && pv[2];
    wd  = pd[2];
    drp = 1'b0;
    if (en) begin
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = v;     pd[0] = w;
    end
    if (pop) void'(mq.pop_front());
    if (wr) begin
      if (mq.size() < 4) mq.push_back(wd);
      else drp = 1'b1;
    end
    if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else if (drp) begin
      m_sticky = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    chk("res_valid", res_valid, mq.size() > 0);
    if (mq.size() > 0) chk("res_data", res_data, mq[0]);
    chk("ovf_sticky", ovf_sticky, m_sticky);
    chk("drop_cnt", drop_cnt, 40'(m_cnt));
  endtask

  function automatic logic [39:0] rand_frac();
    logic [63:0] r;
    logic [39:0] x;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: x = {{24{r[15]}}, r[15:0]};
      1: x = r[39:0];
      2: begin
        x = 40'd1 << $urandom_range(0, 39);
        if (r[40]) x = ~x + 40'd1;
      end
      3: x = 40'h7FFF_FFFF + 40'($urandom_range(0, 4)) - 40'd2;
      default: x = 40'hFF_8000_0000 + 40'($urandom_range(0, 4)) - 40'd2;
    endcase
    return x;
  endfunction

  typedef struct {
    logic [1:0]  fmt;
    logic [7:0]  exp;
    logic [39:0] frac;
    logic        b200;
    logic [31:0] want;
  } vec_t;

  vec_t vt [16];
  int   lat;

  initial begin
    vt[0]  = '{2'b10, 8'd50,  40'd1,              1'b0, 32'h3F80_0000};
    vt[1]  = '{2'b10, 8'd50,  40'hFF_FFFF_FFFD,   1'b0, 32'hC040_0000};
    vt[2]  = '{2'b10, 8'd50,  40'h00_0200_0001,   1'b0, 32'h4C00_0000};
    vt[3]  = '{2'b10, 8'd50,  40'h00_0200_0003,   1'b0, 32'h4C00_0001};
    vt[4]  = '{2'b10, 8'd51,  40'h00_0100_0001,   1'b0, 32'h4C00_0000};
    vt[5]  = '{2'b10, 8'd200, 40'd0,              1'b0, 32'h0000_0000};
    vt[6]  = '{2'b10, 8'd255, 40'd1,              1'b0, 32'h7F80_0000};
    vt[7]  = '{2'b10, 8'd50,  40'h80_0000_0000,   1'b0, 32'hD300_0000};
    vt[8]  = '{2'b10, 8'd0,   40'd1,              1'b1, 32'h0000_0000};
    vt[9]  = '{2'b01, 8'd9,   40'hFF_FFFF_FFFB,   1'b0, 32'hFFFF_FFFB};
    vt[10] = '{2'b01, 8'd0,   40'h00_8000_0000,   1'b0, 32'h7FFF_FFFF};
    vt[11] = '{2'b01, 8'd0,   40'hF8_0000_0000,   1'b0, 32'h8000_0000};
    vt[12] = '{2'b00, 8'd0,   40'hFF_FFFF_FF80,   1'b0, 32'hFFFF_FF80};
    vt[13] = '{2'b10, 8'd50,  40'h00_01FF_FFFF,   1'b0, 32'h4C00_0000};
    vt[14] = '{2'b01, 8'd0,   40'h00_7FFF_FFFF,   1'b0, 32'h7FFF_FFFF};
    vt[15] = '{2'b01, 8'd0,   40'hFF_8000_0000,   1'b0, 32'h8000_0000};

    areset = 1'b1; aclken = 1'b1; mac_out_valid = 1'b0; res_ready = 1'b0; ovf_clr = 1'b0;
    calfmt = 2'b10; mac_out_exp = '0; mac_out_frac = '0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 8'd0);

    // Single results: visible after the third edge following the input edge.
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      calfmt = vt[i].fmt; mac_out_exp = vt[i].exp; mac_out_frac = vt[i].frac;
      mac_out_valid = 1'b1;
      cycle();
      mac_out_valid = 1'b0;
      cycle();
      cycle();
      chk($sformatf("vec%0d_early", i), res_valid, 1'b0);
      cycle();
      if (vt[i].b200) begin
        chk($sformatf("vec%0d_b_valid", i), res_valid_b, 1'b1);
        chk($sformatf("vec%0d_b_data", i), res_data_b, vt[i].want);
      end else begin
        chk($sformatf("vec%0d_valid", i), res_valid, 1'b1);
        chk($sformatf("vec%0d_data", i), res_data, vt[i].want);
      end
      cycle();
      chk($sformatf("vec%0d_popped", i), res_valid, 1'b0);
    end

    // Backpressure: six results into a four-entry FIFO.
    res_ready = 1'b0; calfmt = 2'b10; mac_out_exp = 8'd50;
    for (int k = 1; k <= 6; k++) begin
      mac_out_frac = 40'(k); mac_out_valid = 1'b1;
      cycle();
    end
    mac_out_valid = 1'b0;
    repeat (4) cycle();
    chk("bp_valid", res_valid, 1'b1);
    chk("bp_sticky", ovf_sticky, 1'b1);
    chk("bp_drop_cnt", drop_cnt, 8'd2);
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp_order%0d", k), res_data, ref_fp(40'(k), 50, 50));
      cycle();
    end
    chk("bp_drained", res_valid, 1'b0);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("clr_sticky", ovf_sticky, 1'b0);
    chk("clr_drop_cnt", drop_cnt, 8'd0);

    // Reset with three results in flight.
    for (int k = 0; k < 3; k++) begin
      mac_out_frac = 40'(k + 7); mac_out_valid = 1'b1;
      cycle();
    end
    mac_out_valid = 1'b0;
    areset = 1'b1;
    #1;
    chk("midrst_valid", res_valid, 1'b0);
    model_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (6) cycle();

    // Clock-enable stall of five cycles after three back-to-back inputs.
    for (int k = 0; k < 3; k++) begin
      mac_out_frac = 40'(100 + k); mac_out_valid = 1'b1;
      cycle();
    end
    mac_out_valid = 1'b0;
    aclken = 1'b0;
    repeat (5) cycle();
    aclken = 1'b1;
    lat = 7;
    while (!res_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("stall_latency", 40'(lat), 40'd8);
    repeat (4) cycle();

    // Randomized streams, one segment per format, drained between segments.
    for (int f = 0; f < 3; f++) begin
      calfmt = (f == 0) ? 2'b10 : (f == 1) ? 2'b01 : 2'b00;
      repeat (400) begin
        mac_out_valid = ($urandom_range(0, 3) != 0);
        mac_out_frac  = rand_frac();
        mac_out_exp   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(40, 70)) : 8'($urandom_range(0, 255));
        res_ready     = ($urandom_range(0, 3) != 0);
        aclken        = ($urandom_range(0, 7) != 0);
        ovf_clr       = ($urandom_range(0, 31) == 0);
        cycle();
      end
      mac_out_valid = 1'b0; res_ready = 1'b1; aclken = 1'b1; ovf_clr = 1'b0;
      repeat (10) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
